// File: rtl/hydra_pkg.sv
// Shared constants and control-frame header layout for the port-side switch logic.
package hydra_pkg;

  localparam int unsigned PORT_NUM = 16;
  localparam int unsigned PORT_W   = 4;
  localparam int unsigned PRI_W    = 3;
  localparam int unsigned LEN_W    = 9;

  // Field order matches the 16-bit control frame: length in the MSBs, dest in the LSBs.
  typedef struct packed {
    logic [LEN_W-1:0]  length;
    logic [PRI_W-1:0]  prior;
    logic [PORT_W-1:0] dest;
  } ctrl_hdr_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first candidate at or after rr_ptr, wrapping.
// With SEARCH_ARB_PRIO_EN, candidates are first narrowed to the highest priority present.
module rr_pick
  import hydra_pkg::*;
(
  input  logic [PORT_NUM-1:0]       eligible,
  input  logic [PORT_W-1:0]         rr_ptr,
  input  logic [PORT_NUM*PRI_W-1:0] prior,
  output logic                      hit,
  output logic [PORT_W-1:0]         index
);

  logic [PORT_NUM-1:0] cand;
  logic [PORT_W-1:0]   pos;
  logic                found;

`ifdef SEARCH_ARB_PRIO_EN
  logic [PRI_W-1:0] top;

  always_comb begin
    top = '0;
    for (int unsigned i = 0; i < PORT_NUM; i++) begin
      if (eligible[i] && (prior[i*PRI_W +: PRI_W] > top)) top = prior[i*PRI_W +: PRI_W];
    end
    for (int unsigned i = 0; i < PORT_NUM; i++) begin
      cand[i] = eligible[i] && (prior[i*PRI_W +: PRI_W] == top);
    end
  end
`else
  logic unused_prior;
  assign unused_prior = ^prior;
  assign cand = eligible;
`endif

  always_comb begin
    hit   = |cand;
    index = '0;
    found = 1'b0;
    pos   = '0;
    for (int unsigned off = 0; off < PORT_NUM; off++) begin
      pos = PORT_W'((32'(rr_ptr) + off) % PORT_NUM);
      if (!found && cand[pos]) begin
        found = 1'b1;
        index = pos;
      end
    end
  end

endmodule

// File: rtl/search_arbiter.sv
// Queues one control-frame header per port and issues them one at a time to the
// shared free-space search engine. Define SEARCH_ARB_PRIO_EN for priority-first picking.
module search_arbiter
  import hydra_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic [PORT_NUM-1:0]        pkt_new,
  input  logic [PORT_NUM*PORT_W-1:0] pkt_dest,
  input  logic [PORT_NUM*PRI_W-1:0]  pkt_prior,
  input  logic [PORT_NUM*LEN_W-1:0]  pkt_length,
  input  logic [PORT_NUM-1:0]        pkt_start,
  output logic                       srch_req,
  output logic [PORT_W-1:0]          srch_port,
  output logic [PORT_W-1:0]          srch_dest,
  output logic [PRI_W-1:0]           srch_prior,
  output logic [LEN_W-1:0]           srch_length,
  input  logic                       srch_ack,
  input  logic                       srch_ok,
  output logic [PORT_NUM-1:0]        search_get,
  output logic                       ovf
);

  arb_state_t                state, state_nxt;
  ctrl_hdr_t                 hdr [PORT_NUM];
  logic [PORT_NUM-1:0]       pending;
  logic [PORT_NUM-1:0]       inflight;
  logic [PORT_NUM-1:0]       eligible;
  logic [PORT_NUM*PRI_W-1:0] prior_vec;
  logic [PORT_W-1:0]         rr_ptr;
  logic [PORT_W-1:0]         pick;
  logic                      hit;
  logic                      issue;
  logic                      take;
  logic                      take_ok;
  logic                      renew;

  for (genvar g = 0; g < PORT_NUM; g++) begin : g_prior
    assign prior_vec[g*PRI_W +: PRI_W] = hdr[g].prior;
  end

  assign inflight = srch_req ? (PORT_NUM'(1) << srch_port) : '0;
  assign eligible = pending & ~search_get & ~inflight;
  assign take_ok  = take & srch_ok;

  rr_pick u_pick (
    .eligible (eligible),
    .rr_ptr   (rr_ptr),
    .prior    (prior_vec),
    .hit      (hit),
    .index    (pick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // IDLE always lasts at least one cycle, leaving a bubble between requests.
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    take      = 1'b0;
    case (state)
      ST_IDLE: if (hit) begin
        issue     = 1'b1;
        state_nxt = ST_REQ;
      end
      ST_REQ: if (srch_ack) begin
        take      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Issued request registers, round-robin pointer and in-flight refresh tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      srch_req    <= 1'b0;
      srch_port   <= '0;
      srch_dest   <= '0;
      srch_prior  <= '0;
      srch_length <= '0;
      rr_ptr      <= '0;
      renew       <= 1'b0;
    end else begin
      if (issue) begin
        srch_req    <= 1'b1;
        srch_port   <= pick;
        srch_dest   <= hdr[pick].dest;
        srch_prior  <= hdr[pick].prior;
        srch_length <= hdr[pick].length;
        renew       <= 1'b0;
      end else if (take) begin
        srch_req <= 1'b0;
        rr_ptr   <= (srch_port == PORT_W'(PORT_NUM - 1)) ? '0 : srch_port + PORT_W'(1);
      end
      if (srch_req && pkt_new[srch_port]) renew <= 1'b1;
    end
  end

  // Per-port header queue and grant; a fresh header always beats an ack for the old one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending    <= '0;
      search_get <= '0;
      ovf        <= 1'b0;
      for (int unsigned p = 0; p < PORT_NUM; p++) hdr[p] <= '0;
    end else begin
      for (int unsigned p = 0; p < PORT_NUM; p++) begin
        if (pkt_new[p]) begin
          hdr[p]        <= {pkt_length[p*LEN_W +: LEN_W], pkt_prior[p*PRI_W +: PRI_W],
                            pkt_dest[p*PORT_W +: PORT_W]};
          pending[p]    <= 1'b1;
          search_get[p] <= 1'b0;
          if (pending[p]) ovf <= 1'b1;
        end else if (take_ok && (srch_port == PORT_W'(p))) begin
          search_get[p] <= 1'b1;
          if (!renew) pending[p] <= 1'b0;
        end else if (pkt_start[p]) begin
          search_get[p] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_search_arbiter.sv
// Bench for search_arbiter: directed vector table, multi-cycle corner sequences and a
// randomized run against a transaction-level reference model.
module tb_search_arbiter;
  import hydra_pkg::*;

  localparam int PN = 16;

  logic                       clk = 1'b0;
  logic                       rst;
  logic [PORT_NUM-1:0]        pkt_new;
  logic [PORT_NUM*PORT_W-1:0] pkt_dest;
  logic [PORT_NUM*PRI_W-1:0]  pkt_prior;
  logic [PORT_NUM*LEN_W-1:0]  pkt_length;
  logic [PORT_NUM-1:0]        pkt_start;
  logic                       srch_req;
  logic [PORT_W-1:0]          srch_port;
  logic [PORT_W-1:0]          srch_dest;
  logic [PRI_W-1:0]           srch_prior;
  logic [LEN_W-1:0]           srch_length;
  logic                       srch_ack;
  logic                       srch_ok;
  logic [PORT_NUM-1:0]        search_get;
  logic                       ovf;
  logic [15:0]                out_hdr;

  search_arbiter dut (
    .clk(clk), .rst(rst), .pkt_new(pkt_new), .pkt_dest(pkt_dest), .pkt_prior(pkt_prior),
    .pkt_length(pkt_length), .pkt_start(pkt_start), .srch_req(srch_req), .srch_port(srch_port),
    .srch_dest(srch_dest), .srch_prior(srch_prior), .srch_length(srch_length),
    .srch_ack(srch_ack), .srch_ok(srch_ok), .search_get(search_get), .ovf(ovf)
  );

  assign out_hdr = {srch_length, srch_prior, srch_dest};

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          port;
    int          dest;
    int          prior;
    int          len;
    bit          ok;
    int          exp_port;
    logic [15:0] exp_hdr;
    bit          exp_get;
  } vec_t;

  vec_t tbl [4];

  // Reference model state: what each port has queued and what the engine sees.
  bit          m_pend [PN];
  logic [15:0] m_hdr  [PN];
  bit          m_get  [PN];
  bit          m_ovf;
  int          m_rr;
  bit          m_req;
  int          m_port;
  logic [15:0] m_out;
  bit          m_fresh;
  logic [15:0] r_hdr  [PN];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] hdr_of(input int d, input int pr, input int len);
    return {9'(len), 3'(pr), 4'(d)};
  endfunction

  task automatic post(input int p, input int d, input int pr, input int len);
    logic [15:0] h;
    h = hdr_of(d, pr, len);
    pkt_new[p] = 1'b1;
    pkt_dest[p*PORT_W +: PORT_W]   = h[3:0];
    pkt_prior[p*PRI_W +: PRI_W]    = h[6:4];
    pkt_length[p*LEN_W +: LEN_W]   = h[15:7];
  endtask

  task automatic commit();
    step();
    pkt_new   = '0;
    pkt_start = '0;
  endtask

  task automatic ack(input bit ok);
    srch_ack = 1'b1;
    srch_ok  = ok;
    step();
    srch_ack = 1'b0;
    srch_ok  = 1'b0;
  endtask

  task automatic do_reset();
    pkt_new = '0; pkt_start = '0; srch_ack = 1'b0; srch_ok = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic wait_req(input string name, input int exp_port);
    int n;
    n = 0;
    while (!srch_req && n < 20) begin
      step();
      n++;
    end
    if (!srch_req) begin
      checks++;
      errors++;
      $display("FAIL %s: no srch_req within 20 cycles, expected port %0d", name, exp_port);
    end else begin
      check(name, 64'(srch_port), 64'(exp_port));
    end
  endtask

  task automatic idle_cycles(input string name, input int n);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      step();
      seen = seen | srch_req;
    end
    check(name, 64'(seen), 64'(0));
  endtask

  // ---------------- reference model ----------------
  task automatic model_reset();
    for (int p = 0; p < PN; p++) begin
      m_pend[p] = 1'b0; m_hdr[p] = '0; m_get[p] = 1'b0;
    end
    m_ovf = 1'b0; m_rr = 0; m_req = 1'b0; m_port = 0; m_out = '0; m_fresh = 1'b0;
  endtask

  // Scan ports from the rotating pointer; optionally keep only a strictly higher priority.
  function automatic int model_pick();
    int best;
    int best_pri;
    int p;
    best = -1;
    best_pri = -1;
    for (int k = 0; k < PN; k++) begin
      p = (m_rr + k) % PN;
      if (m_pend[p] && !m_get[p] && !(m_req && p == m_port)) begin
`ifdef SEARCH_ARB_PRIO_EN
        if (int'(m_hdr[p][6:4]) > best_pri) begin
          best = p;
          best_pri = int'(m_hdr[p][6:4]);
        end
`else
        if (best < 0) best = p;
`endif
      end
    end
    return best;
  endfunction

  task automatic model_update(input logic [PN-1:0] nv, input logic [PN-1:0] sv,
                              input bit a, input bit o);
    bit          take, take_ok, old_req, old_fresh;
    int          old_port, pk;
    logic [15:0] pk_hdr;
    old_req   = m_req;
    old_port  = m_port;
    old_fresh = m_fresh;
    take      = old_req && a;
    take_ok   = take && o;
    pk        = old_req ? -1 : model_pick();
    pk_hdr    = (pk >= 0) ? m_hdr[pk] : 16'h0;
    for (int p = 0; p < PN; p++) begin
      if (nv[p]) begin
        if (m_pend[p]) m_ovf = 1'b1;
        m_pend[p] = 1'b1;
        m_hdr[p]  = r_hdr[p];
        m_get[p]  = 1'b0;
      end else if (take_ok && p == old_port) begin
        m_get[p] = 1'b1;
        if (!old_fresh) m_pend[p] = 1'b0;
      end else if (sv[p]) begin
        m_get[p] = 1'b0;
      end
    end
    if (pk >= 0) begin
      m_req = 1'b1; m_port = pk; m_out = pk_hdr; m_fresh = 1'b0;
    end
    if (take) begin
      m_req = 1'b0;
      m_rr  = (old_port + 1) % PN;
    end
    if (old_req && nv[old_port]) m_fresh = 1'b1;
  endtask

  task automatic run_random(input int cycles);
    logic [PN-1:0] nv, sv, gv;
    bit a, o;
    do_reset();
    model_reset();
    for (int cyc = 0; cyc < cycles; cyc++) begin
      if (cyc % 400 == 399) begin
        do_reset();
        model_reset();
      end
      nv = '0;
      sv = '0;
      for (int p = 0; p < PN; p++) begin
        r_hdr[p] = '0;
        if ($urandom_range(0, 79) == 0) begin
          nv[p] = 1'b1;
          r_hdr[p] = 16'($urandom);
        end
        if (m_get[p] && $urandom_range(0, 5) == 0) sv[p] = 1'b1;
      end
      a = m_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
      o = ($urandom_range(0, 3) != 0);
      pkt_new = nv;
      pkt_start = sv;
      for (int p = 0; p < PN; p++) begin
        pkt_dest[p*PORT_W +: PORT_W] = r_hdr[p][3:0];
        pkt_prior[p*PRI_W +: PRI_W]  = r_hdr[p][6:4];
        pkt_length[p*LEN_W +: LEN_W] = r_hdr[p][15:7];
      end
      srch_ack = a;
      srch_ok  = o;
      model_update(nv, sv, a, o);
      step();
      for (int p = 0; p < PN; p++) gv[p] = m_get[p];
      check("random", 64'({srch_req, srch_port, out_hdr, search_get, ovf}),
            64'({m_req, 4'(m_port), m_out, gv, m_ovf}));
    end
    pkt_new = '0; pkt_start = '0; srch_ack = 1'b0; srch_ok = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    pkt_new = '0; pkt_start = '0; pkt_dest = '0; pkt_prior = '0; pkt_length = '0;
    srch_ack = 1'b0; srch_ok = 1'b0;

    tbl[0] = '{3, 5, 2, 64, 1'b1, 3, 16'h2025, 1'b1};
    tbl[1] = '{15, 15, 7, 511, 1'b1, 15, 16'hFFFF, 1'b1};
    tbl[2] = '{0, 0, 0, 1, 1'b0, 0, 16'h0080, 1'b0};
    tbl[3] = '{9, 10, 3, 300, 1'b1, 9, 16'h963A, 1'b1};

    step();
    step();
    check("reset_req", 64'(srch_req), 64'(0));
    check("reset_get", 64'(search_get), 64'(0));
    check("reset_ovf", 64'(ovf), 64'(0));
    check("reset_srch_fields", 64'({srch_port, out_hdr}), 64'(0));
    rst = 1'b0;

    // Single-request vectors: 2-cycle latency, header pass-through, grant or retry.
    for (int i = 0; i < 4; i++) begin
      do_reset();
      post(tbl[i].port, tbl[i].dest, tbl[i].prior, tbl[i].len);
      commit();
      check($sformatf("vec%0d_req_lat1", i), 64'(srch_req), 64'(0));
      step();
      check($sformatf("vec%0d_req_lat2", i), 64'(srch_req), 64'(1));
      check($sformatf("vec%0d_port", i), 64'(srch_port), 64'(tbl[i].exp_port));
      check($sformatf("vec%0d_hdr", i), 64'(out_hdr), 64'(tbl[i].exp_hdr));
      ack(tbl[i].ok);
      check($sformatf("vec%0d_req_drop", i), 64'(srch_req), 64'(0));
      check($sformatf("vec%0d_get", i), 64'(search_get[tbl[i].port]), 64'(tbl[i].exp_get));
      if (tbl[i].ok) begin
        pkt_start[tbl[i].port] = 1'b1;
        commit();
        check($sformatf("vec%0d_get_clr", i), 64'(search_get), 64'(0));
        check($sformatf("vec%0d_no_reissue", i), 64'(srch_req), 64'(0));
      end else begin
        step();
        check($sformatf("vec%0d_reissue", i), 64'({srch_req, srch_port}), 64'({1'b1, 4'(tbl[i].port)}));
      end
    end

    // Spurious ack while idle is ignored.
    do_reset();
    ack(1'b1);
    check("spurious_ack", 64'({srch_req, search_get}), 64'(0));

    // Fairness: rr_ptr moved to 1, then ports 0,1,15 posted together.
    do_reset();
    post(0, 1, 3, 20);
    commit();
    wait_req("fair_setup", 0);
    ack(1'b1);
    post(0, 2, 3, 21); post(1, 3, 3, 22); post(15, 4, 3, 23);
    commit();
    wait_req("fair_first", 1);
    ack(1'b1);
    wait_req("fair_second", 15);
    ack(1'b1);
    wait_req("fair_third", 0);
    ack(1'b1);

    // Retry: port 4 refused while port 9 pending.
    do_reset();
    post(4, 1, 2, 40);
    commit();
    wait_req("retry_first", 4);
    post(9, 2, 2, 90);
    commit();
    ack(1'b0);
    wait_req("retry_other", 9);
    check("retry_get4_a", 64'(search_get[4]), 64'(0));
    ack(1'b1);
    wait_req("retry_again", 4);
    check("retry_get4_b", 64'(search_get[4]), 64'(0));
    ack(1'b1);
    check("retry_get4_c", 64'(search_get[4]), 64'(1));

    // Overwrite while pending, then a refresh while in flight.
    do_reset();
    post(5, 0, 0, 5);
    commit();
    wait_req("ovw_block", 5);
    post(2, 1, 1, 10);
    commit();
    check("ovw_ovf_clear", 64'(ovf), 64'(0));
    post(2, 6, 3, 200);
    commit();
    check("ovw_ovf_set", 64'(ovf), 64'(1));
    ack(1'b1);
    wait_req("ovw_issue", 2);
    check("ovw_hdr_second", 64'(out_hdr), 64'(hdr_of(6, 3, 200)));
    post(2, 9, 4, 33);
    commit();
    check("ovw_hold_stable", 64'(out_hdr), 64'(hdr_of(6, 3, 200)));
    ack(1'b1);
    check("ovw_get2", 64'(search_get[2]), 64'(1));
    idle_cycles("ovw_wait_grant", 3);
    pkt_start[2] = 1'b1;
    commit();
    wait_req("ovw_reissue", 2);
    check("ovw_hdr_third", 64'(out_hdr), 64'(hdr_of(9, 4, 33)));

    // Priority vs pure round-robin with rr_ptr at 0.
    do_reset();
    post(1, 0, 1, 11);
    post(6, 0, 7, 66);
    commit();
`ifdef SEARCH_ARB_PRIO_EN
    wait_req("prio_first", 6);
`else
    wait_req("prio_first", 1);
`endif

    // Asynchronous reset in the middle of a request.
    do_reset();
    post(3, 1, 1, 1);
    commit();
    wait_req("arst_setup3", 3);
    ack(1'b1);
    post(7, 2, 2, 2);
    commit();
    wait_req("arst_setup7", 7);
    post(10, 3, 3, 3);
    commit();
    post(10, 4, 4, 4);
    commit();
    check("arst_pre", 64'({srch_req, search_get[3], ovf}), 64'(3'b111));
    #2 rst = 1'b1;
    #1;
    check("arst_now", 64'({srch_req, search_get, ovf}), 64'(0));
    step();
    rst = 1'b0;
    idle_cycles("arst_no_issue", 10);

    run_random(3000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
